// File: rtl/afu_conf_ctrl_if.sv
// Signal bundle between the host-side driver and afu_conf_ctrl: CSR write port,
// AFU status/control vectors and the descriptor valid/ready channel.
interface afu_conf_ctrl_if #(
  parameter int NUM_AFUS = 16
);
  logic                csr_wr_en;
  logic [3:0]          csr_wr_addr;
  logic [63:0]         csr_wr_data;
  logic [NUM_AFUS-1:0] afu_done;
  logic                conf_ready;
  logic                conf_valid;
  logic [1:0]          conf_type;
  logic [127:0]        conf;
  logic [NUM_AFUS-1:0] start_afus;
  logic [NUM_AFUS-1:0] rst_afus;
  logic [NUM_AFUS-1:0] done_mask;
  logic [63:0]         total_clocks;
  logic [63:0]         status;

  modport master (
    output csr_wr_en, csr_wr_addr, csr_wr_data, afu_done, conf_ready,
    input  conf_valid, conf_type, conf, start_afus, rst_afus, done_mask,
           total_clocks, status
  );

  modport slave (
    input  csr_wr_en, csr_wr_addr, csr_wr_data, afu_done, conf_ready,
    output conf_valid, conf_type, conf, start_afus, rst_afus, done_mask,
           total_clocks, status
  );
endinterface

// File: rtl/afu_conf_ctrl.sv
// Host-control front end: decodes CSR writes into AFU start/stop/reset controls and
// queues 128-bit configuration descriptors in a first-word-fall-through FIFO.
module afu_conf_ctrl #(
  parameter int NUM_AFUS        = 16,
  parameter int CONF_FIFO_DEPTH = 8,
  parameter int RST_PULSE_LEN   = 4
) (
  input logic            clk,
  input logic            rst,
  afu_conf_ctrl_if.slave bus
);

  localparam int PW = $clog2(CONF_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(CONF_FIFO_DEPTH);
  localparam logic [7:0]    PULSE_LEN  = 8'(RST_PULSE_LEN);

  typedef enum logic [3:0] {
    CSR_DSM_LOW  = 4'd0,
    CSR_DSM_HIGH = 4'd1,
    CSR_IN_LOW   = 4'd2,
    CSR_IN_HIGH  = 4'd3,
    CSR_OUT_LOW  = 4'd4,
    CSR_OUT_HIGH = 4'd5,
    CSR_START    = 4'd6,
    CSR_STOP     = 4'd7,
    CSR_RESET    = 4'd8,
    CSR_CLEAR    = 4'd9
  } csr_e;

  logic [63:0]         r_staging;
  logic [127:0]        r_fifoData [CONF_FIFO_DEPTH];
  logic [1:0]          r_fifoType [CONF_FIFO_DEPTH];
  logic [PW-1:0]       r_wrPtr;
  logic [PW-1:0]       r_rdPtr;
  logic [CW-1:0]       r_count;
  logic                r_confValid;
  logic [1:0]          r_confType;
  logic [127:0]        r_conf;
  logic [NUM_AFUS-1:0] r_start;
  logic [NUM_AFUS-1:0] r_done;
  logic [NUM_AFUS-1:0] r_rstAfus;
  logic [7:0]          r_rstCnt [NUM_AFUS];
  logic                r_overflow;
  logic [63:0]         r_total;
  logic [63:0]         r_status;

  logic                w_lowWr;
  logic                w_highWr;
  logic [1:0]          w_pushType;
  logic                w_startWr;
  logic                w_stopWr;
  logic                w_resetWr;
  logic                w_clearWr;
  logic [NUM_AFUS-1:0] w_data;
  logic [127:0]        w_pushWord;
  logic                w_pop;
  logic                w_full;
  logic                w_push;
  logic                w_dropped;
  logic [CW-1:0]       w_countAfterPop;
  logic [CW-1:0]       w_countNext;
  logic [PW-1:0]       w_rdPtrNext;
  logic                w_headValid;
  logic [1:0]          w_headType;
  logic [127:0]        w_headData;
  logic [7:0]          w_rstCntNext [NUM_AFUS];
  logic [NUM_AFUS-1:0] w_rstNext;
  logic [NUM_AFUS-1:0] w_rstBlock;
  logic [NUM_AFUS-1:0] w_complete;
  logic [NUM_AFUS-1:0] w_startNext;
  logic [NUM_AFUS-1:0] w_doneNext;
  logic                w_overflowNext;
  logic [63:0]         w_totalNext;

  always_comb begin
    w_lowWr    = 1'b0;
    w_highWr   = 1'b0;
    w_pushType = 2'd0;
    w_startWr  = 1'b0;
    w_stopWr   = 1'b0;
    w_resetWr  = 1'b0;
    w_clearWr  = 1'b0;
    if (bus.csr_wr_en) begin
      case (bus.csr_wr_addr)
        CSR_DSM_LOW, CSR_IN_LOW, CSR_OUT_LOW: w_lowWr = 1'b1;
        CSR_DSM_HIGH: begin w_highWr = 1'b1; w_pushType = 2'd3; end
        CSR_IN_HIGH:  begin w_highWr = 1'b1; w_pushType = 2'd1; end
        CSR_OUT_HIGH: begin w_highWr = 1'b1; w_pushType = 2'd2; end
        CSR_START:    w_startWr = 1'b1;
        CSR_STOP:     w_stopWr  = 1'b1;
        CSR_RESET:    w_resetWr = 1'b1;
        CSR_CLEAR:    w_clearWr = 1'b1;
        default:      ;
      endcase
    end
  end

  assign w_data     = bus.csr_wr_data[NUM_AFUS-1:0];
  assign w_pushWord = {bus.csr_wr_data, r_staging};

  // A simultaneous pop frees a slot, so a push into a full FIFO is only dropped without one.
  assign w_pop           = r_confValid && bus.conf_ready;
  assign w_full          = (r_count == FULL_COUNT);
  assign w_push          = w_highWr && (!w_full || w_pop);
  assign w_dropped       = w_highWr && w_full && !w_pop;
  assign w_countAfterPop = r_count - CW'(w_pop);
  assign w_countNext     = w_countAfterPop + CW'(w_push);
  assign w_rdPtrNext     = r_rdPtr + PW'(w_pop);

  always_comb begin
    w_headValid = 1'b0;
    w_headType  = 2'd0;
    w_headData  = '0;
    if (w_countAfterPop != '0) begin
      w_headValid = 1'b1;
      w_headType  = r_fifoType[w_rdPtrNext];
      w_headData  = r_fifoData[w_rdPtrNext];
    end else if (w_push) begin
      w_headValid = 1'b1;
      w_headType  = w_pushType;
      w_headData  = w_pushWord;
    end
  end

  always_comb begin
    w_rstCntNext = r_rstCnt;
    w_rstNext    = '0;
    for (int i = 0; i < NUM_AFUS; i++) begin
      if (w_resetWr && w_data[i]) begin
        w_rstCntNext[i] = PULSE_LEN;
      end else if (r_rstCnt[i] != 8'd0) begin
        w_rstCntNext[i] = r_rstCnt[i] - 8'd1;
      end
      w_rstNext[i] = (w_rstCntNext[i] != 8'd0);
    end
  end

  // Blocking on both the current and next pulse state ignores any START landing inside a pulse.
  assign w_rstBlock  = r_rstAfus | w_rstNext;
  assign w_complete  = bus.afu_done & r_start;
  assign w_startNext = ((r_start & ~(w_stopWr ? w_data : '0) & ~w_complete)
                        | (w_startWr ? w_data : '0)) & ~w_rstBlock;
  assign w_doneNext  = (((w_clearWr && bus.csr_wr_data[1]) ? '0 : r_done) | w_complete)
                       & ~w_rstBlock;
  assign w_overflowNext = (r_overflow && !(w_clearWr && bus.csr_wr_data[0])) || w_dropped;
  assign w_totalNext    = (w_clearWr && bus.csr_wr_data[2]) ? 64'd0
                          : r_total + {63'd0, |r_start};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_staging   <= '0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_confValid <= 1'b0;
      r_confType  <= '0;
      r_conf      <= '0;
      r_start     <= '0;
      r_done      <= '0;
      r_rstAfus   <= '0;
      r_overflow  <= 1'b0;
      r_total     <= '0;
      r_status    <= '0;
      for (int i = 0; i < NUM_AFUS; i++) r_rstCnt[i] <= '0;
    end else begin
      if (w_lowWr) r_staging <= bus.csr_wr_data;
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      r_rdPtr     <= w_rdPtrNext;
      r_count     <= w_countNext;
      r_confValid <= w_headValid;
      r_confType  <= w_headType;
      r_conf      <= w_headData;
      r_start     <= w_startNext;
      r_done      <= w_doneNext;
      r_rstAfus   <= w_rstNext;
      r_rstCnt    <= w_rstCntNext;
      r_overflow  <= w_overflowNext;
      r_total     <= w_totalNext;
      r_status    <= {54'd0, (w_doneNext != '0) && (w_startNext == '0),
                      w_overflowNext, 8'(w_countNext)};
    end
  end

  // Descriptor storage needs no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= w_pushWord;
      r_fifoType[r_wrPtr] <= w_pushType;
    end
  end

  assign bus.conf_valid   = r_confValid;
  assign bus.conf_type    = r_confType;
  assign bus.conf         = r_conf;
  assign bus.start_afus   = r_start;
  assign bus.rst_afus     = r_rstAfus;
  assign bus.done_mask    = r_done;
  assign bus.total_clocks = r_total;
  assign bus.status       = r_status;

endmodule

// File: tb/tb_afu_conf_ctrl.sv
// Self-checking bench for afu_conf_ctrl: descriptors are checked through a scoreboard
// queue, control/status outputs against constants derived from the CSR behaviour.
module tb_afu_conf_ctrl;

  localparam logic [3:0] A_DSM_LOW  = 4'd0;
  localparam logic [3:0] A_DSM_HIGH = 4'd1;
  localparam logic [3:0] A_IN_LOW   = 4'd2;
  localparam logic [3:0] A_IN_HIGH  = 4'd3;
  localparam logic [3:0] A_OUT_LOW  = 4'd4;
  localparam logic [3:0] A_OUT_HIGH = 4'd5;
  localparam logic [3:0] A_START    = 4'd6;
  localparam logic [3:0] A_STOP     = 4'd7;
  localparam logic [3:0] A_RESET    = 4'd8;
  localparam logic [3:0] A_CLEAR    = 4'd9;

  logic clk;
  logic rst;
  int   compareCount;
  int   mismatchCount;
  logic [63:0]  stagingModel;
  logic [129:0] sbQ [$];
  logic [129:0] headWord;

  afu_conf_ctrl_if #(.NUM_AFUS(16)) busIf ();

  afu_conf_ctrl #(
    .NUM_AFUS(16),
    .CONF_FIFO_DEPTH(8),
    .RST_PULSE_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [129:0] observed,
                             input logic [129:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drives one CSR write for a single edge; HIGH writes expected to be accepted go to the scoreboard.
  task automatic applyStimulus(input logic [3:0] addr, input logic [63:0] data,
                               input bit expectPush);
    logic [1:0] t;
    t = 2'd0;
    if (addr == A_DSM_HIGH) t = 2'd3;
    if (addr == A_IN_HIGH)  t = 2'd1;
    if (addr == A_OUT_HIGH) t = 2'd2;
    busIf.csr_wr_en   = 1'b1;
    busIf.csr_wr_addr = addr;
    busIf.csr_wr_data = data;
    if (expectPush) sbQ.push_back({t, data, stagingModel});
    if (addr == A_DSM_LOW || addr == A_IN_LOW || addr == A_OUT_LOW) stagingModel = data;
    @(negedge clk);
    busIf.csr_wr_en = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int budget;
    budget = 40;
    while (sbQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sbQ.size() != 0) checkOutput(tag, 130'(sbQ.size()), 130'd0);
  endtask

  // The handshake is judged just before the edge that would complete it.
  always begin
    @(negedge clk);
    #2;
    if (!rst && busIf.conf_valid && busIf.conf_ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDesc", 130'd1, 130'd0);
      end else begin
        checkOutput("descriptor", {busIf.conf_type, busIf.conf}, sbQ.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compareCount      = 0;
    mismatchCount     = 0;
    stagingModel      = 64'd0;
    rst               = 1'b1;
    busIf.csr_wr_en   = 1'b0;
    busIf.csr_wr_addr = 4'd0;
    busIf.csr_wr_data = 64'd0;
    busIf.afu_done    = 16'd0;
    busIf.conf_ready  = 1'b0;
    tick(3);
    checkOutput("rstValid",  130'(busIf.conf_valid), 130'd0);
    checkOutput("rstStart",  130'(busIf.start_afus), 130'd0);
    checkOutput("rstPulse",  130'(busIf.rst_afus), 130'd0);
    checkOutput("rstDone",   130'(busIf.done_mask), 130'd0);
    checkOutput("rstTotal",  130'(busIf.total_clocks), 130'd0);
    checkOutput("rstStatus", 130'(busIf.status), 130'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] single descriptor");
    busIf.conf_ready = 1'b1;
    applyStimulus(A_IN_LOW, 64'h1000, 1'b0);
    applyStimulus(A_IN_HIGH, 64'h0, 1'b1);
    checkOutput("singleValid", 130'(busIf.conf_valid), 130'd1);
    tick(1);
    checkOutput("singleDrop", 130'(busIf.conf_valid), 130'd0);
    checkOutput("singleEmpty", 130'(sbQ.size()), 130'd0);

    $display("[TB] fill FIFO while stalled");
    busIf.conf_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] lowA;
      lowA = (k % 3 == 0) ? A_DSM_LOW : ((k % 3 == 1) ? A_IN_LOW : A_OUT_LOW);
      applyStimulus(lowA, {32'hA5A5_0000, 32'(k)}, 1'b0);
      applyStimulus(lowA + 4'd1, {32'(k), $urandom}, k < 8);
    end
    checkOutput("fullOcc", 130'(busIf.status[7:0]), 130'd8);
    checkOutput("fullOvf", 130'(busIf.status[8]), 130'd1);
    headWord = sbQ[0];
    for (int s = 0; s < 3; s++) begin
      checkOutput("stallHead", {busIf.conf_type, busIf.conf}, headWord);
      tick(1);
    end
    applyStimulus(A_CLEAR, 64'h1, 1'b0);
    checkOutput("ovfCleared", 130'(busIf.status[8:0]), 130'h008);

    $display("[TB] push and pop on full FIFO");
    busIf.conf_ready = 1'b1;
    applyStimulus(A_OUT_HIGH, 64'hFEED_0000_CAFE_0001, 1'b1);
    checkOutput("ppOcc", 130'(busIf.status[8:0]), 130'h008);
    waitDrain("drainTimeout1");
    tick(1);
    checkOutput("drainValid", 130'(busIf.conf_valid), 130'd0);
    checkOutput("drainOcc", 130'(busIf.status[7:0]), 130'd0);

    $display("[TB] start/complete/stop");
    applyStimulus(A_START, 64'h5, 1'b0);
    checkOutput("startBits", 130'(busIf.start_afus), 130'h5);
    checkOutput("totalZero", 130'(busIf.total_clocks), 130'd0);
    tick(5);
    checkOutput("total5", 130'(busIf.total_clocks), 130'd5);
    busIf.afu_done = 16'h1;
    tick(1);
    busIf.afu_done = 16'h0;
    checkOutput("complStart", 130'(busIf.start_afus), 130'h4);
    checkOutput("complDone", 130'(busIf.done_mask), 130'h1);
    checkOutput("complTotal", 130'(busIf.total_clocks), 130'd6);
    checkOutput("notAllDone", 130'(busIf.status[9]), 130'd0);
    tick(2);
    applyStimulus(A_STOP, 64'h4, 1'b0);
    checkOutput("stopStart", 130'(busIf.start_afus), 130'h0);
    checkOutput("allDone", 130'(busIf.status[9]), 130'd1);
    checkOutput("stopTotal", 130'(busIf.total_clocks), 130'd9);
    tick(3);
    checkOutput("frozenTotal", 130'(busIf.total_clocks), 130'd9);

    $display("[TB] clear with same-cycle completion");
    busIf.conf_ready = 1'b0;
    for (int k = 0; k < 9; k++) applyStimulus(A_DSM_HIGH, {$urandom, 32'(k)}, k < 8);
    checkOutput("refill", 130'(busIf.status[8:0]), 130'h108);
    applyStimulus(A_START, 64'h4, 1'b0);
    busIf.afu_done = 16'h4;
    applyStimulus(A_CLEAR, 64'h7, 1'b0);
    busIf.afu_done = 16'h0;
    checkOutput("clrStatus", 130'(busIf.status[9:0]), 130'h208);
    checkOutput("clrTotal", 130'(busIf.total_clocks), 130'd0);
    checkOutput("clrDone", 130'(busIf.done_mask), 130'h4);
    checkOutput("clrStart", 130'(busIf.start_afus), 130'h0);
    busIf.conf_ready = 1'b1;
    waitDrain("drainTimeout2");
    busIf.conf_ready = 1'b0;

    $display("[TB] reset pulses");
    applyStimulus(A_START, 64'h3, 1'b0);
    applyStimulus(A_RESET, 64'h2, 1'b0);
    checkOutput("pulse1", 130'(busIf.rst_afus), 130'h2);
    checkOutput("pulseStart", 130'(busIf.start_afus), 130'h1);
    tick(1);
    checkOutput("pulse2", 130'(busIf.rst_afus), 130'h2);
    applyStimulus(A_START, 64'h2, 1'b0);
    checkOutput("pulse3", 130'(busIf.rst_afus), 130'h2);
    checkOutput("startIgnored", 130'(busIf.start_afus), 130'h1);
    tick(1);
    checkOutput("pulse4", 130'(busIf.rst_afus), 130'h2);
    tick(1);
    checkOutput("pulseEnd", 130'(busIf.rst_afus), 130'h0);
    checkOutput("pulseEndStart", 130'(busIf.start_afus), 130'h1);
    applyStimulus(A_RESET, 64'h4, 1'b0);
    checkOutput("rstClrDone", 130'(busIf.done_mask), 130'h0);
    checkOutput("rstBit2", 130'(busIf.rst_afus), 130'h4);
    tick(4);

    $display("[TB] reset mid-transfer");
    applyStimulus(A_IN_HIGH, 64'h11, 1'b1);
    applyStimulus(A_OUT_HIGH, 64'h22, 1'b1);
    checkOutput("preRstValid", 130'(busIf.conf_valid), 130'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    sbQ.delete();
    stagingModel = 64'd0;
    checkOutput("midRstValid", 130'(busIf.conf_valid), 130'd0);
    checkOutput("midRstStatus", 130'(busIf.status), 130'd0);
    checkOutput("midRstStart", 130'(busIf.start_afus), 130'd0);
    busIf.conf_ready = 1'b1;
    tick(3);
    checkOutput("postRstValid", 130'(busIf.conf_valid), 130'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/afu_conf_ctrl.md
# afu_conf_ctrl

Parametrised host-control front end sitting between the CSR manager and `afu_manager`: decodes CPU CSR writes into per-AFU start/stop/reset controls and 128-bit configuration descriptors. Descriptors are queued in a FIFO and delivered with a valid/ready handshake, so back-to-back host configuration writes are never lost while the manager is busy. The block also auto-clears start bits on AFU completion, tracks sticky per-AFU done flags, and generates timed per-AFU reset pulses. It replaces the single-cycle, unbuffered configuration path in the AFU top level.

## Interface
Parameters:
- `NUM_AFUS`, 16, number of AFUs controlled (1..64).
- `CONF_FIFO_DEPTH`, 8, descriptor FIFO entries (power of 2, ≥2).
- `RST_PULSE_LEN`, 4, cycles each `rst_afus` bit is held high (1..255).

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous reset, active-high.
- `csr_wr_en` in 1: CSR write strobe.
- `csr_wr_addr` in 4: CSR index.
- `csr_wr_data` in 64: CSR write data.
- `afu_done` in NUM_AFUS: level, AFU i finished.
- `conf_ready` in 1: manager accepts a descriptor.
- `conf_valid` out 1: descriptor available.
- `conf_type` out 2: 1 = IN_DATA, 2 = OUT_DATA, 3 = OUT_DSM.
- `conf` out 128: descriptor {high, low}.
- `start_afus` out NUM_AFUS: run enables.
- `rst_afus` out NUM_AFUS: per-AFU reset pulses.
- `done_mask` out NUM_AFUS: sticky completion flags.
- `total_clocks` out 64: cycles with any AFU running.
- `status` out 64: [7:0] FIFO occupancy, [8] overflow sticky, [9] all started AFUs done, rest 0.

## Operation
- CSR map: 0 DSM_LOW, 1 DSM_HIGH, 2 IN_LOW, 3 IN_HIGH, 4 OUT_LOW, 5 OUT_HIGH, 6 START, 7 STOP, 8 RESET, 9 CLEAR. Indices 10–15 are ignored.
- Any `*_LOW` write loads a shared 64-bit staging register.
- A `*_HIGH` write pushes {type, data, staging} into the FIFO. Type is taken from the address pair.
  - Staging is not cleared by the push.
  - If the FIFO is full and no pop occurs that cycle, the push is dropped and `status[8]` is set.
- FIFO is first-word-fall-through. `conf`/`conf_type` are stable while `conf_valid && !conf_ready`. A pop occurs on `conf_valid && conf_ready`.
- START: `start_afus |= data[NUM_AFUS-1:0]`. STOP: `start_afus &= ~data`. Upper data bits are ignored.
- Completion: if `afu_done[i] && start_afus[i]`, clear `start_afus[i]` and set `done_mask[i]`.
  - A START write to bit i in the same cycle wins: the bit stays set, and `done_mask[i]` is still set.
- RESET write: every bit set in data loads that AFU's pulse counter with `RST_PULSE_LEN`.
  - `rst_afus[i]` is high while its counter is nonzero.
  - `start_afus[i]` and `done_mask[i]` are forced to 0 while `rst_afus[i]` is high; this overrides START.
  - A RESET write to an AFU already in reset reloads its counter.
- CLEAR: data bit 0 clears overflow, bit 1 clears `done_mask`, bit 2 zeroes `total_clocks`. A completion in the same cycle as bit 1 leaves its flag set.
- `total_clocks` increments each cycle `|start_afus` is true and wraps at 2^64.
- `status[9]` = `(done_mask != 0) && (start_afus == 0)`.

## Timing
- All outputs are registered. Reset values: every output is 0, the FIFO is empty, staging = 0, and pulse counters = 0.
- CSR write at edge t: effect is visible after edge t+1 (1-cycle latency).
- Push at t into an empty FIFO: `conf_valid` is high from t+1.
- Pop at t: the next entry is presented at t+1; `conf_valid` drops at t+1 if the FIFO is now empty.
- Push and pop in the same cycle: occupancy is unchanged, and the push is accepted even when the FIFO is full.
- Maximum throughput is one descriptor per cycle.
- `rst_afus[i]` is high for exactly `RST_PULSE_LEN` cycles starting t+1.
- Asserting `rst` mid-transfer discards queued descriptors and drops `conf_valid` the next cycle.

## Test plan
- Writes IN_LOW=0x1000, IN_HIGH=0x0 with `conf_ready`=1 -> one cycle of `conf_valid` with `conf`={0x0,0x1000} and `conf_type`=1.
- `conf_ready`=0 and 10 HIGH writes at DEPTH=8 -> occupancy 8, `status[8]`=1. Then with ready=1 -> exactly 8 descriptors pop in push order, and the data is stable while stalled.
- Full FIFO with a HIGH write and a pop in the same cycle -> write accepted, occupancy stays 8, overflow not set.
- START=0x5; `afu_done[0]` pulses at cycle 20 -> `start_afus`=0x4, `done_mask`=0x1, `total_clocks` keeps counting. Then STOP=0x4 -> `status[9]`=1 and `total_clocks` freezes.
- Set `start_afus`=0x3, then RESET=0x2 with RST_PULSE_LEN=4 -> `rst_afus[1]` high for 4 cycles and `start_afus`=0x1. A START=0x2 issued during the pulse is ignored.
- CLEAR=0x7 while `afu_done[2]` completes the same cycle -> overflow=0, `total_clocks`=0, `done_mask`=0x4.
